// File: rtl/recover_pkg.sv
// Shared types and constants for the recovery output reorder buffer.
//   DATA_WIDTH   : width of each real/imag sample
//   LANES        : complex samples per group
//   IDX_WIDTH    : width of the column index tags
//   lane_vec_t   : one column of LANES samples
//   cplx_group_t : one group (LANES real + LANES imag words)
//   rd_state_t   : reader FSM states
`timescale 1ns/1ps
package recover_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned LANES      = 4;
    localparam int unsigned IDX_WIDTH  = 11;

    typedef logic [LANES-1:0][DATA_WIDTH-1:0] lane_vec_t;

    typedef struct packed {
        lane_vec_t re;
        lane_vec_t im;
    } cplx_group_t;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } rd_state_t;

endpackage

// File: rtl/recover_frame_buffer_if.sv
// Beat input and group output bus of the reorder buffer.
//   in_valid, in_col{1,2}_{r,i}, in_index_col{1,2} : upstream beat (no stall)
//   out_valid/out_ready                           : downstream handshake
//   out_data_{r,i}, out_group, out_last           : one output group
//   overflow                                      : sticky dropped-beat flag
// slave = buffer side, master = upstream/downstream side.
`timescale 1ns/1ps
interface recover_frame_buffer_if #(
    parameter int unsigned GADDR_W = 9
) ();
    import recover_pkg::*;

    logic                 in_valid;
    lane_vec_t            in_col1_r;
    lane_vec_t            in_col1_i;
    lane_vec_t            in_col2_r;
    lane_vec_t            in_col2_i;
    logic [IDX_WIDTH-1:0] in_index_col1;
    logic [IDX_WIDTH-1:0] in_index_col2;

    logic                 out_valid;
    logic                 out_ready;
    lane_vec_t            out_data_r;
    lane_vec_t            out_data_i;
    logic [GADDR_W-1:0]   out_group;
    logic                 out_last;
    logic                 overflow;

    modport slave (
        input  in_valid, in_col1_r, in_col1_i, in_col2_r, in_col2_i,
               in_index_col1, in_index_col2, out_ready,
        output out_valid, out_data_r, out_data_i, out_group, out_last, overflow
    );

    modport master (
        output in_valid, in_col1_r, in_col1_i, in_col2_r, in_col2_i,
               in_index_col1, in_index_col2, out_ready,
        input  out_valid, out_data_r, out_data_i, out_group, out_last, overflow
    );

endinterface

// File: rtl/frame_bank_ram.sv
// One frame bank: two write ports (port 2 wins on equal address) and one
// registered, enabled read port. Contents are never reset.
//   clk            : clock
//   we1/waddr1/wdata1, we2/waddr2/wdata2 : write ports
//   re/raddr/rdata : read port, rdata updates one cycle after re
`timescale 1ns/1ps
module frame_bank_ram
    import recover_pkg::*;
#(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we1,
    input  logic [AW-1:0] waddr1,
    input  cplx_group_t   wdata1,
    input  logic          we2,
    input  logic [AW-1:0] waddr2,
    input  cplx_group_t   wdata2,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output cplx_group_t   rdata
);

    cplx_group_t mem [DEPTH];

    // Port 1 is suppressed on an address collision so port 2 data lands.
    always_ff @(posedge clk) begin
        if (we1 && !(we2 && (waddr1 == waddr2))) begin
            mem[waddr1] <= wdata1;
        end
        if (we2) begin
            mem[waddr2] <= wdata2;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/recover_frame_buffer.sv
// Reorder buffer after the recovery butterfly: writes indexed groups into a
// ping-pong pair of banks and streams each completed frame in group order.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : beat input, group output handshake and overflow flag
`timescale 1ns/1ps
module recover_frame_buffer
    import recover_pkg::*;
#(
    parameter int unsigned FRAME_BEATS = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    recover_frame_buffer_if.slave  bus
);

    localparam int unsigned GROUPS  = 2 * FRAME_BEATS;
    localparam int unsigned GADDR_W = $clog2(GROUPS);
    localparam int unsigned BCNT_W  = $clog2(FRAME_BEATS + 1);
    localparam logic [GADDR_W-1:0] LAST_GROUP = GADDR_W'(GROUPS - 1);
    localparam logic [BCNT_W-1:0]  LAST_BEAT  = BCNT_W'(FRAME_BEATS - 1);

    // Write side state
    logic               wr_bank;
    logic [BCNT_W-1:0]  beat_cnt;
    logic [1:0]         bank_full;
    logic               overflow_q;

    // Read side: stage 1 is the RAM read register, stage 2 the output hold
    rd_state_t          state;
    logic               rd_bank;
    logic [GADDR_W-1:0] rd_group;
    logic               fetch_done;
    logic               q_vld;
    logic [GADDR_W-1:0] q_group;
    logic               q_last;
    logic               out_valid_q;
    cplx_group_t        out_grp_q;
    logic [GADDR_W-1:0] out_group_q;
    logic               out_last_q;

    cplx_group_t        col1_c;
    cplx_group_t        col2_c;
    cplx_group_t        q_bank [2];
    cplx_group_t        q_data_c;
    logic               accept_c;
    logic               frame_end_c;
    logic               load_c;
    logic               last_acc_c;
    logic               fetch_c;
    logic [GADDR_W-1:0] fetch_addr_c;
    logic [1:0]         bank_full_nxt_c;
    logic               unused_idx_c;

    assign col1_c       = '{re: bus.in_col1_r, im: bus.in_col1_i};
    assign col2_c       = '{re: bus.in_col2_r, im: bus.in_col2_i};
    assign unused_idx_c = ^{bus.in_index_col1[IDX_WIDTH-1:GADDR_W],
                            bus.in_index_col2[IDX_WIDTH-1:GADDR_W]};

    for (genvar b = 0; b < 2; b++) begin : g_bank
        frame_bank_ram #(.DEPTH(GROUPS)) u_ram (
            .clk    (clk),
            .we1    (accept_c && (wr_bank == 1'(b))),
            .waddr1 (bus.in_index_col1[GADDR_W-1:0]),
            .wdata1 (col1_c),
            .we2    (accept_c && (wr_bank == 1'(b))),
            .waddr2 (bus.in_index_col2[GADDR_W-1:0]),
            .wdata2 (col2_c),
            .re     (fetch_c && (rd_bank == 1'(b))),
            .raddr  (fetch_addr_c),
            .rdata  (q_bank[b])
        );
    end

    assign q_data_c = rd_bank ? q_bank[1] : q_bank[0];

    // Handshake and fetch decisions for this cycle.
    always_comb begin
        accept_c     = bus.in_valid && !bank_full[wr_bank];
        frame_end_c  = accept_c && (beat_cnt == LAST_BEAT);
        load_c       = !out_valid_q || bus.out_ready;
        last_acc_c   = out_valid_q && bus.out_ready && out_last_q;
        fetch_c      = 1'b0;
        fetch_addr_c = rd_group;
        if (state == IDLE) begin
            fetch_c      = bank_full[rd_bank];
            fetch_addr_c = '0;
        end else begin
            fetch_c      = load_c && !fetch_done;
        end
        // Writer set and reader clear target different banks; both apply.
        bank_full_nxt_c = bank_full;
        if (frame_end_c) begin
            bank_full_nxt_c[wr_bank] = 1'b1;
        end
        if (last_acc_c) begin
            bank_full_nxt_c[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_bank     <= 1'b0;
            beat_cnt    <= '0;
            bank_full   <= '0;
            overflow_q  <= 1'b0;
            state       <= IDLE;
            rd_bank     <= 1'b0;
            rd_group    <= '0;
            fetch_done  <= 1'b0;
            q_vld       <= 1'b0;
            q_group     <= '0;
            q_last      <= 1'b0;
            out_valid_q <= 1'b0;
            out_grp_q   <= '0;
            out_group_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            // Writer: count accepted beats, flip banks at frame end.
            if (accept_c) begin
                beat_cnt <= frame_end_c ? '0 : beat_cnt + BCNT_W'(1);
                if (frame_end_c) begin
                    wr_bank <= ~wr_bank;
                end
            end
            if (bus.in_valid && bank_full[wr_bank]) begin
                overflow_q <= 1'b1;
            end
            bank_full <= bank_full_nxt_c;

            // Stage 1: RAM read register bookkeeping.
            if (fetch_c) begin
                q_vld      <= 1'b1;
                q_group    <= fetch_addr_c;
                q_last     <= (fetch_addr_c == LAST_GROUP);
                rd_group   <= fetch_addr_c + GADDR_W'(1);
                fetch_done <= (fetch_addr_c == LAST_GROUP);
            end else if (load_c) begin
                q_vld      <= 1'b0;
            end

            // Stage 2: output hold; only advances when empty or accepted.
            if (load_c) begin
                out_valid_q <= q_vld;
                if (q_vld) begin
                    out_grp_q   <= q_data_c;
                    out_group_q <= q_group;
                    out_last_q  <= q_last;
                end
            end

            // Reader FSM.
            case (state)
                IDLE: begin
                    if (bank_full[rd_bank]) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_acc_c) begin
                        state   <= IDLE;
                        rd_bank <= ~rd_bank;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_data_r = out_grp_q.re;
    assign bus.out_data_i = out_grp_q.im;
    assign bus.out_group  = out_group_q;
    assign bus.out_last   = out_last_q;
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_recover_frame_buffer.sv
// Directed bench for recover_frame_buffer with FRAME_BEATS=4 (8 groups/frame).
`timescale 1ns/1ps
module tb_recover_frame_buffer;
    import recover_pkg::*;

    localparam int unsigned FB = 4;
    localparam int unsigned GW = 3;
    localparam int NG = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    recover_frame_buffer_if #(.GADDR_W(GW)) bus ();
    recover_frame_buffer #(.FRAME_BEATS(FB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    lane_vec_t exp_r [NG];
    lane_vec_t exp_i [NG];
    bit        exp_chk [NG];
    int        cyc_taken;

    // Sample value 4g+k, tagged in the upper bits so stale data is visible.
    function automatic lane_vec_t gen_r(int tag, int g);
        lane_vec_t v;
        for (int k = 0; k < 4; k++) v[k] = 32'((tag << 16) + 4 * g + k);
        return v;
    endfunction

    function automatic lane_vec_t gen_i(int tag, int g);
        lane_vec_t v;
        for (int k = 0; k < 4; k++) v[k] = 32'hA000_0000 | 32'((tag << 20) + 4 * g + k);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_beat(input int t1, input int i1, input int t2, input int i2);
        @(negedge clk);
        bus.in_valid      = 1'b1;
        bus.in_col1_r     = gen_r(t1, i1);
        bus.in_col1_i     = gen_i(t1, i1);
        bus.in_col2_r     = gen_r(t2, i2);
        bus.in_col2_i     = gen_i(t2, i2);
        bus.in_index_col1 = 11'(i1);
        bus.in_index_col2 = 11'(i2);
        @(posedge clk);
        #1;
    endtask

    task automatic stop_input();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic set_exp(input int tag);
        for (int g = 0; g < NG; g++) begin
            exp_r[g]   = gen_r(tag, g);
            exp_i[g]   = gen_i(tag, g);
            exp_chk[g] = 1'b1;
        end
    endtask

    task automatic send_natural(input int tag);
        for (int b = 0; b < 4; b++) send_beat(tag, b, tag, b + 4);
    endtask

    // Called at a negedge. mode 0: always ready; mode 1: ready 1 cycle in 3.
    task automatic collect(input int mode, input string name, output int cycles);
        int g = 0;
        int cyc = 0;
        bit held = 1'b0;
        logic [255:0] sv_d = '0;
        logic [GW-1:0] sv_g = '0;
        logic rdy;
        while (g < NG && cyc < 200) begin
            if (held) begin
                chk($sformatf("%s_hold_valid", name), 256'(bus.out_valid), 256'(1));
                chk($sformatf("%s_hold_data", name), {bus.out_data_r, bus.out_data_i}, sv_d);
                chk($sformatf("%s_hold_group", name), 256'(bus.out_group), 256'(sv_g));
            end
            rdy = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            bus.out_ready = rdy;
            if (bus.out_valid) begin
                if (rdy) begin
                    chk($sformatf("%s_group%0d", name, g), 256'(bus.out_group), 256'(g));
                    chk($sformatf("%s_last%0d", name, g), 256'(bus.out_last), 256'(g == NG - 1));
                    if (exp_chk[g])
                        chk($sformatf("%s_data%0d", name, g),
                            {bus.out_data_r, bus.out_data_i}, {exp_r[g], exp_i[g]});
                    g++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    sv_d = {bus.out_data_r, bus.out_data_i};
                    sv_g = bus.out_group;
                end
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("%s_groups_seen", name), 256'(g), 256'(NG));
        cycles = cyc;
    endtask

    task automatic expect_quiet(input string name, input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            chk(name, 256'(bus.out_valid), 256'(0));
        end
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_valid"}, 256'(bus.out_valid), 256'(0));
        chk({name, "_last"}, 256'(bus.out_last), 256'(0));
        chk({name, "_ovf"}, 256'(bus.overflow), 256'(0));
        chk({name, "_group"}, 256'(bus.out_group), 256'(0));
        chk({name, "_data"}, {bus.out_data_r, bus.out_data_i}, 256'(0));
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.in_valid      = 1'b0;
        bus.in_col1_r     = '0;
        bus.in_col1_i     = '0;
        bus.in_col2_r     = '0;
        bus.in_col2_i     = '0;
        bus.in_index_col1 = '0;
        bus.in_index_col2 = '0;
        bus.out_ready     = 1'b0;

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Natural order frame, with first-output latency check
        send_natural(1);
        stop_input();
        chk("lat_e0", 256'(bus.out_valid), 256'(0));
        @(negedge clk);
        chk("lat_e1", 256'(bus.out_valid), 256'(0));
        @(negedge clk);
        chk("lat_e2_valid", 256'(bus.out_valid), 256'(1));
        chk("lat_e2_group", 256'(bus.out_group), 256'(0));
        set_exp(1);
        collect(0, "nat", cyc_taken);
        chk("nat_no_bubbles", 256'(cyc_taken), 256'(NG));
        expect_quiet("nat_quiet", 3);

        // Bit-reversed style indices still come out in natural order
        send_beat(2, 5, 2, 1);
        send_beat(2, 3, 2, 7);
        send_beat(2, 0, 2, 4);
        send_beat(2, 6, 2, 2);
        stop_input();
        set_exp(2);
        collect(0, "scr", cyc_taken);

        // Backpressure at 1-of-3 ready
        send_natural(3);
        stop_input();
        set_exp(3);
        collect(1, "bp", cyc_taken);
        chk("bp_no_ovf", 256'(bus.overflow), 256'(0));

        // Column collision: col2 data wins at group 3; group 7 is never written
        send_beat(104, 3, 4, 3);
        send_beat(4, 0, 4, 1);
        send_beat(4, 2, 4, 4);
        send_beat(4, 5, 4, 6);
        stop_input();
        set_exp(4);
        exp_chk[7] = 1'b0;
        collect(0, "col", cyc_taken);

        // Overflow: 9 beats with downstream stalled; the 9th is dropped
        bus.out_ready = 1'b0;
        send_natural(5);
        for (int b = 0; b < 4; b++) send_beat(6, b, 6, b + 4);
        chk("ovf_before_9", 256'(bus.overflow), 256'(0));
        send_beat(7, 0, 7, 4);
        chk("ovf_after_9", 256'(bus.overflow), 256'(1));
        stop_input();
        set_exp(5);
        collect(0, "ovf_f0", cyc_taken);
        set_exp(6);
        collect(0, "ovf_f1", cyc_taken);
        expect_quiet("ovf_only_two_frames", 6);
        chk("ovf_sticky", 256'(bus.overflow), 256'(1));

        // Reset mid-stream discards the partial frame
        send_beat(8, 0, 8, 4);
        send_beat(8, 1, 8, 5);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        send_natural(9);
        stop_input();
        set_exp(9);
        collect(0, "post_rst", cyc_taken);
        expect_quiet("post_rst_quiet", 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
